// File: rtl/vga_path_plotter.sv
// Path rasteriser: optional framebuffer clear, Bresenham segments along an
// indexed node path, then a marker pixel per visited node, as a ready/valid write stream.
module vga_path_plotter #(
  parameter int N_NODES = 64,
  parameter int IDX_W   = 6,
  parameter int COORD_W = 8,
  parameter int PIX_W   = 3,
  parameter logic [PIX_W-1:0] LINE_COLOR = 3'b111,
  parameter logic [PIX_W-1:0] NODE_COLOR = 3'b100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_NODES*COORD_W-1:0] xs,
  input  logic [N_NODES*COORD_W-1:0] ys,
  input  logic [N_NODES*IDX_W-1:0]   path,
  input  logic [IDX_W:0]             path_len,
  input  logic                       closed,
  input  logic                       clear_en,
  input  logic                       start,
  output logic                       fb_we,
  input  logic                       fb_ready,
  output logic [COORD_W-1:0]         fb_x,
  output logic [COORD_W-1:0]         fb_y,
  output logic [PIX_W-1:0]           fb_data,
  output logic                       busy,
  output logic                       done
);

  localparam int SW = COORD_W + 2;
  localparam int EW = COORD_W + 3;
  localparam logic [IDX_W:0]     NMAX = (IDX_W+1)'(N_NODES);
  localparam logic [COORD_W-1:0] CMAX = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, SEG_LOAD, SEG_DRAW, NODE, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W:0]      len_q, len_d;
  logic [IDX_W:0]      nseg_q, nseg_d;
  logic [IDX_W:0]      idx_q, idx_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]  x1_q, x1_d, y1_q, y1_d;
  logic signed [SW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                sxn_q, sxn_d, syn_q, syn_d;

  // Entries past the table and node indices past N_NODES both fall back to 0.
  function automatic logic [IDX_W-1:0] pathAt(input logic [N_NODES*IDX_W-1:0] p,
                                               input logic [IDX_W:0] k);
    if (k >= NMAX) return '0;
    return p[k*IDX_W +: IDX_W];
  endfunction

  function automatic logic [COORD_W-1:0] nodeCoord(input logic [N_NODES*COORD_W-1:0] v,
                                                   input logic [IDX_W-1:0] i);
    if ({1'b0, i} >= NMAX) return v[COORD_W-1:0];
    return v[i*COORD_W +: COORD_W];
  endfunction

  logic [IDX_W:0]       lenIn, nsegIn, idxNext;
  logic [IDX_W-1:0]     segA, segB, nodeIdx;
  logic [COORD_W-1:0]   ax, ay, bx, by;
  logic signed [SW-1:0] diffX, diffY, absX, negAbsY;
  logic signed [EW-1:0] e2, dxExt, dyExt;
  logic                 stepX, stepY, atEnd, accept;

  assign lenIn   = (path_len > NMAX) ? NMAX : path_len;
  assign nsegIn  = (lenIn < 2) ? '0 : (closed ? lenIn : lenIn - 1'b1);
  assign idxNext = idx_q + 1'b1;

  // The closing segment wraps back to path[0]; open paths never reach it.
  assign segA    = pathAt(path, idx_q);
  assign segB    = (idxNext < len_q) ? pathAt(path, idxNext) : pathAt(path, '0);
  assign nodeIdx = segA;
  assign ax      = nodeCoord(xs, segA);
  assign ay      = nodeCoord(ys, segA);
  assign bx      = nodeCoord(xs, segB);
  assign by      = nodeCoord(ys, segB);
  assign diffX   = $signed({2'b00, bx}) - $signed({2'b00, ax});
  assign diffY   = $signed({2'b00, by}) - $signed({2'b00, ay});
  assign absX    = diffX[SW-1] ? -diffX : diffX;
  assign negAbsY = diffY[SW-1] ? diffY : -diffY;

  assign e2      = {err_q, 1'b0};
  assign dxExt   = {dx_q[SW-1], dx_q};
  assign dyExt   = {dy_q[SW-1], dy_q};
  assign stepX   = (e2 >= dyExt);
  assign stepY   = (e2 <= dxExt);
  assign atEnd   = (x_q == x1_q) && (y_q == y1_q);
  assign accept  = fb_we && fb_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      nseg_q  <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      nseg_q  <= nseg_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    nseg_d  = nseg_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d  = lenIn;
          nseg_d = nsegIn;
          idx_d  = '0;
          x_d    = '0;
          y_d    = '0;
          if (clear_en)          state_d = CLEAR;
          else if (nsegIn != 0)  state_d = SEG_LOAD;
          else if (lenIn != 0)   state_d = NODE;
          else                   state_d = DONE;
        end
      end
      CLEAR: begin
        if (accept) begin
          if (x_q == CMAX) begin
            x_d = '0;
            if (y_q == CMAX) begin
              idx_d = '0;
              if (nseg_q != 0)     state_d = SEG_LOAD;
              else if (len_q != 0) state_d = NODE;
              else                 state_d = DONE;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      SEG_LOAD: begin
        x_d     = ax;
        y_d     = ay;
        x1_d    = bx;
        y1_d    = by;
        dx_d    = absX;
        dy_d    = negAbsY;
        err_d   = absX + negAbsY;
        sxn_d   = diffX[SW-1];
        syn_d   = diffY[SW-1];
        state_d = SEG_DRAW;
      end
      SEG_DRAW: begin
        if (accept) begin
          if (atEnd) begin
            if (idxNext < nseg_q) begin
              idx_d   = idxNext;
              state_d = SEG_LOAD;
            end else begin
              idx_d   = '0;
              state_d = NODE;
            end
          end else begin
            err_d = err_q + (stepX ? dy_q : '0) + (stepY ? dx_q : '0);
            if (stepX) x_d = sxn_q ? x_q - 1'b1 : x_q + 1'b1;
            if (stepY) y_d = syn_q ? y_q - 1'b1 : y_q + 1'b1;
          end
        end
      end
      NODE: begin
        if (accept) begin
          if (idxNext == len_q) state_d = DONE;
          else                  idx_d   = idxNext;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fb_we   = 1'b0;
    fb_x    = '0;
    fb_y    = '0;
    fb_data = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        fb_we = 1'b1;
        fb_x  = x_q;
        fb_y  = y_q;
        busy  = 1'b1;
      end
      SEG_LOAD: busy = 1'b1;
      SEG_DRAW: begin
        fb_we   = 1'b1;
        fb_x    = x_q;
        fb_y    = y_q;
        fb_data = LINE_COLOR;
        busy    = 1'b1;
      end
      NODE: begin
        fb_we   = 1'b1;
        fb_x    = nodeCoord(xs, nodeIdx);
        fb_y    = nodeCoord(ys, nodeIdx);
        fb_data = NODE_COLOR;
        busy    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_path_plotter.sv
// Self-checking bench for vga_path_plotter: directed table, corner sequences and
// randomized paths against a pixel-list reference model.
module tb_vga_path_plotter;

  localparam int N  = 6;
  localparam int IW = 3;
  localparam int CW = 4;
  localparam int PW = 3;
  localparam int LC = 7;
  localparam int NC = 4;
  localparam int BUDGET = 3000;

  logic            clk = 1'b0;
  logic            rst, start, closed, clear_en, fb_ready;
  logic [N*CW-1:0] xs, ys;
  logic [N*IW-1:0] path;
  logic [IW:0]     path_len;
  logic            fb_we, busy, done;
  logic [CW-1:0]   fb_x, fb_y;
  logic [PW-1:0]   fb_data;

  always #5 clk = ~clk;

  vga_path_plotter #(
    .N_NODES(N), .IDX_W(IW), .COORD_W(CW), .PIX_W(PW),
    .LINE_COLOR(3'b111), .NODE_COLOR(3'b100)
  ) dut (
    .clk(clk), .rst(rst), .xs(xs), .ys(ys), .path(path), .path_len(path_len),
    .closed(closed), .clear_en(clear_en), .start(start), .fb_we(fb_we),
    .fb_ready(fb_ready), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  typedef struct { int x; int y; int d; } pix_t;
  typedef struct {
    string name;
    int x0, y0, x1, y1, x2, y2;
    int p0, p1, p2;
    int len, closed, expW, expL, expF;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  pix_t expQ[$];
  pix_t gotQ[$];
  int   xsV[N], ysV[N], pathV[N];
  int   lenV, closedV, clearV;

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drivePorts();
    for (int i = 0; i < N; i++) begin
      xs[i*CW +: CW]   = CW'(xsV[i]);
      ys[i*CW +: CW]   = CW'(ysV[i]);
      path[i*IW +: IW] = IW'(pathV[i]);
    end
    path_len = (IW+1)'(lenV);
    closed   = closedV[0];
    clear_en = clearV[0];
  endtask

  task automatic plotLine(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    forever begin
      expQ.push_back('{x, y, LC});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Reference: the full list of pixel writes a job must produce, in order.
  task automatic buildModel(output int nseg);
    int len, a, b;
    expQ.delete();
    len  = (lenV > N) ? N : lenV;
    nseg = (len < 2) ? 0 : (closedV != 0 ? len : len - 1);
    if (clearV != 0)
      for (int y = 0; y < (1 << CW); y++)
        for (int x = 0; x < (1 << CW); x++)
          expQ.push_back('{x, y, 0});
    for (int k = 0; k < nseg; k++) begin
      a = pathV[k];
      b = (k + 1 < len) ? pathV[k+1] : pathV[0];
      if (a >= N) a = 0;
      if (b >= N) b = 0;
      plotLine(xsV[a], ysV[a], xsV[b], ysV[b]);
    end
    for (int k = 0; k < len; k++) begin
      a = (pathV[k] >= N) ? 0 : pathV[k];
      expQ.push_back('{xsV[a], ysV[a], NC});
    end
  endtask

  // mode 0: ready always high; 1: random ready plus stray starts; 2: ready low on cycles 3..5.
  task automatic applyStimulus(input string name, input int mode, input int expW,
                               input int expL, input int expF);
    int nseg, cyc, idx, stalls, doneCyc, firstW;
    bit prevStall;
    int px, py, pd;
    buildModel(nseg);
    gotQ.delete();
    idx = 0; stalls = 0; doneCyc = -1; firstW = -1; prevStall = 0;
    px = 0; py = 0; pd = 0;
    @(negedge clk);
    drivePorts();
    start = 1'b1;
    fb_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    forever begin
      case (mode)
        1:       fb_ready = ($urandom_range(0, 9) < 7);
        2:       fb_ready = !(cyc >= 3 && cyc <= 5);
        default: fb_ready = 1'b1;
      endcase
      start = (mode == 1) && ($urandom_range(0, 19) == 0);
      if (prevStall) begin
        checkOutput({name, " hold we"}, int'(fb_we), 1);
        checkOutput({name, " hold xyd"}, {fb_x, fb_y, fb_data}, {px[CW-1:0], py[CW-1:0], pd[PW-1:0]});
      end
      if (done) begin
        start = 1'b0;
        doneCyc = cyc;
        checkOutput({name, " busy at done"}, int'(busy), 0);
        break;
      end
      if (fb_we && fb_ready) begin
        gotQ.push_back('{int'(fb_x), int'(fb_y), int'(fb_data)});
        if (idx < expQ.size())
          checkOutput($sformatf("%s pixel %0d", name, idx), {fb_x, fb_y, fb_data},
                      {expQ[idx].x[CW-1:0], expQ[idx].y[CW-1:0], expQ[idx].d[PW-1:0]});
        else
          checkOutput({name, " extra write"}, idx, expQ.size() - 1);
        if (firstW < 0) firstW = cyc;
        idx++;
      end
      prevStall = fb_we && !fb_ready;
      if (prevStall) stalls++;
      px = int'(fb_x); py = int'(fb_y); pd = int'(fb_data);
      if (cyc >= BUDGET) begin
        checkOutput({name, " timeout"}, cyc, -1);
        start = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    fb_ready = 1'b1;
    checkOutput({name, " write count"}, idx, expQ.size());
    checkOutput({name, " latency"}, doneCyc, 1 + expQ.size() + nseg + stalls);
    if (expW >= 0) checkOutput({name, " table writes"}, idx, expW);
    if (expL >= 0) checkOutput({name, " table latency"}, doneCyc, expL);
    if (expF >= 0) checkOutput({name, " first write cycle"}, firstW, expF);
    @(negedge clk);
    checkOutput({name, " done pulse width"}, int'(done), 0);
    checkOutput({name, " idle after done"}, int'(busy | fb_we), 0);
  endtask

  task automatic loadVec(input vec_t v);
    for (int i = 0; i < N; i++) begin xsV[i] = 0; ysV[i] = 0; pathV[i] = 0; end
    xsV[0] = v.x0; ysV[0] = v.y0; xsV[1] = v.x1; ysV[1] = v.y1; xsV[2] = v.x2; ysV[2] = v.y2;
    pathV[0] = v.p0; pathV[1] = v.p1; pathV[2] = v.p2;
    lenV = v.len; closedV = v.closed; clearV = 0;
  endtask

  vec_t tbl[7];
  int   shX[7];
  int   shY[7];
  int   cnt;

  initial begin
    tbl[0] = '{"horiz",     2, 3, 6, 3, 0, 0,  0, 1, 0,  2, 0,  7,  9,  2};
    tbl[1] = '{"shallow",   7, 1, 1, 4, 0, 0,  0, 1, 0,  2, 0,  9, 11,  2};
    tbl[2] = '{"tri closed",0, 0, 4, 0, 0, 4,  0, 1, 2,  3, 1, 18, 22,  2};
    tbl[3] = '{"tri open",  0, 0, 4, 0, 0, 4,  0, 1, 2,  3, 0, 13, 16,  2};
    tbl[4] = '{"tri len1",  0, 0, 4, 0, 0, 4,  0, 1, 2,  1, 1,  1,  2,  1};
    tbl[5] = '{"empty",     0, 0, 4, 0, 0, 4,  0, 1, 2,  0, 1,  0,  1, -1};
    tbl[6] = '{"bad index", 2, 3, 6, 3, 0, 0,  7, 1, 0,  2, 0,  7,  9,  2};
    shX = '{7, 6, 5, 4, 3, 2, 1};
    shY = '{1, 2, 2, 3, 3, 4, 4};

    rst = 1'b1; start = 1'b1; fb_ready = 1'b1;
    loadVec(tbl[0]);
    drivePorts();
    repeat (3) @(negedge clk);
    checkOutput("reset fb_we", int'(fb_we), 0);
    checkOutput("reset fb_x", int'(fb_x), 0);
    checkOutput("reset fb_y", int'(fb_y), 0);
    checkOutput("reset fb_data", int'(fb_data), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    rst = 1'b0; start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("post-reset quiet", int'(fb_we | busy | done), 0);

    for (int i = 0; i < 7; i++) begin
      loadVec(tbl[i]);
      applyStimulus(tbl[i].name, 0, tbl[i].expW, tbl[i].expL, tbl[i].expF);
      if (tbl[i].name == "shallow")
        for (int k = 0; k < 7; k++)
          checkOutput($sformatf("shallow point %0d", k),
                      (k < gotQ.size()) ? gotQ[k].x * 16 + gotQ[k].y : -1,
                      shX[k] * 16 + shY[k]);
    end

    loadVec(tbl[0]);
    applyStimulus("backpressure", 2, 7, 12, 2);

    // Reset in the middle of a clear, then a full clear-and-draw restart.
    loadVec(tbl[0]);
    clearV = 1;
    @(negedge clk);
    drivePorts();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (fb_we && fb_ready) begin
        checkOutput($sformatf("clear raster %0d", cnt), int'(fb_x) + 16 * int'(fb_y) + 256 * int'(fb_data), cnt);
        cnt++;
      end
      if (cnt == 100) break;
      @(negedge clk);
    end
    checkOutput("clear writes before reset", cnt, 100);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-run reset fb_we", int'(fb_we), 0);
    checkOutput("mid-run reset busy", int'(busy), 0);
    rst = 1'b0;
    applyStimulus("clear restart", 0, 263, 265, 1);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        xsV[i]   = $urandom_range(0, 15);
        ysV[i]   = $urandom_range(0, 15);
        pathV[i] = $urandom_range(0, 7);
      end
      lenV    = $urandom_range(0, 15);
      closedV = $urandom_range(0, 1);
      clearV  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      applyStimulus($sformatf("rand%0d", r), 1, -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_path_plotter.md
# vga_path_plotter

Parametrised path-rasterising engine for the VGA graph display. It takes the same node/path description the graph display consumes: packed node coordinates plus an ordered list of node indices. On a start pulse it optionally clears the framebuffer, then draws every path segment as a Bresenham line and overlays a marker pixel on each visited node. Output is a pixel-write stream with ready/valid backpressure into the framebuffer write port, which the scan-out side reads independently.

## Interface

Parameters:

- N_NODES, 64: number of nodes in xs/ys.
- IDX_W, 6: width of one path index; 2^IDX_W >= N_NODES.
- COORD_W, 8: width of one coordinate; framebuffer is 2^COORD_W x 2^COORD_W.
- PIX_W, 3: width of framebuffer pixel data.
- LINE_COLOR, 3'b111: pixel value written for segment pixels.
- NODE_COLOR, 3'b100: pixel value written for node markers.

Ports:

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- xs  in  N_NODES*COORD_W  node i x-coordinate at [i*COORD_W +: COORD_W].
- ys  in  N_NODES*COORD_W  node i y-coordinate, same packing.
- path  in  N_NODES*IDX_W  entry k at [k*IDX_W +: IDX_W].
- path_len  in  IDX_W+1  number of valid path entries; values > N_NODES are clamped to N_NODES.
- closed  in  1  1 adds the segment path[last] -> path[0].
- clear_en  in  1  1 zero-fills the framebuffer before drawing.
- start  in  1  start request; honoured only in IDLE.
- fb_we  out  1  pixel write valid.
- fb_ready  in  1  framebuffer accepts; a write completes on a cycle with fb_we && fb_ready.
- fb_x, fb_y  out  COORD_W each  pixel coordinate.
- fb_data  out  PIX_W  pixel value.
- busy  out  1  high from the cycle after accepted start until DONE.
- done  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, CLEAR, SEG_LOAD, SEG_DRAW, NODE, DONE.
- On start in IDLE:
  - Latch path_len (clamped), closed and clear_en.
  - xs/ys/path must be held stable by the driver while busy.
  - Next state is CLEAR if clear_en, else SEG_LOAD if nseg > 0, else NODE if path_len > 0, else DONE.
- Segment count nseg:
  - path_len < 2: nseg = 0, including when closed.
  - Open path: nseg = path_len-1.
  - Closed path: nseg = path_len.
  - Segment k runs path[k] -> path[k+1]. The closing segment runs path[path_len-1] -> path[0].
- CLEAR:
  - Writes 0 to every pixel in raster order, x fastest, from (0,0) to (max,max).
  - Leaves after the last accepted write.
- SEG_LOAD (1 cycle, fb_we=0):
  - dx=|x1-x0|, dy=-|y1-y0|, sx/sy = ±1, err = dx+dy.
  - Signed arithmetic in COORD_W+2 bits; e2 = 2*err in COORD_W+3 bits.
- SEG_DRAW:
  - Presents the current (x,y) with LINE_COLOR.
  - On an accepted write: if (x,y)==(x1,y1), the segment ends. Otherwise, if e2 >= dy then err += dy, x += sx; if e2 <= dx then err += dx, y += sy. Both updates use the same e2.
  - Both endpoints are plotted; shared endpoints are rewritten.
  - After the last segment, go to NODE if path_len > 0.
- NODE: one write per entry, path[0..path_len-1], at the node coordinate with NODE_COLOR. Markers overwrite line pixels.
- DONE: busy=0, done=1 for one cycle, then IDLE.
- Path indices >= N_NODES select node 0.

## Timing

- Reset values: fb_we=0, fb_x=0, fb_y=0, fb_data=0, busy=0, done=0, state IDLE.
- rst has priority over start in the same cycle.
- rst asserted mid-operation:
  - fb_we=0 and busy=0 after that edge.
  - No partial state survives.
  - The next start begins from scratch.
- start while busy: ignored.
- Cycle counts with fb_ready=1 and start sampled at edge T:
  - State at T+1 is the first non-IDLE state.
  - CLEAR costs 2^(2*COORD_W) cycles.
  - Each segment costs 1 + max(dx,|dy|) + 1 cycles.
  - NODE costs path_len cycles.
  - DONE costs 1 cycle.
- Backpressure:
  - While fb_we && !fb_ready, fb_x/fb_y/fb_data/fb_we hold and no state advances.
  - Each low-ready cycle adds exactly one cycle; no pixel is skipped or duplicated.
- fb_we is 0 in IDLE, SEG_LOAD and DONE.

## Test plan

- Reset: hold rst with start=1 -> all outputs 0; after release, no activity until a new start.
- Horizontal line: node0=(2,3), node1=(6,3), path=[0,1], path_len=2, open, clear_en=0, start at T. Required:
  - T+1: SEG_LOAD, fb_we=0.
  - T+2..T+6: writes x=2..6, y=3, LINE_COLOR.
  - T+7, T+8: NODE_COLOR at (2,3), then (6,3).
  - T+9: done=1, busy=0.
- Shallow line: node0=(7,1), node1=(1,4) -> line writes, in order: (7,1), (6,2), (5,2), (4,3), (3,3), (2,4), (1,4).
- Closed vs open triangle: nodes (0,0), (4,0), (0,4), path_len=3.
  - closed=1: 3 segments, the last ending at (0,0), then 3 node writes.
  - closed=0: 2 segments.
  - path_len=1: only 1 node write.
- Backpressure: drop fb_ready for 3 cycles mid-segment -> outputs held, identical pixel sequence, completion 3 cycles later.
- Clear plus reset: COORD_W=4, clear_en=1.
  - Required: 256 zero writes in raster order, then segment draws.
  - Assert rst at write 100: fb_we=0 next cycle.
  - Restart: clearing begins again at (0,0).
